// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor_pkg
// Purpose : Shared types and constants for the bit-serial subtractor.
//           state_t          - controller states (IDLE/RUN/DONE)
//           SS_WIDTH_DEFAULT - default operand/result width
// Revision: 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

  localparam int SS_WIDTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : full_subtractor
// Purpose : One-bit full subtractor computing a - b - bin.
// Ports   : a, b  - operand bits
//           bin   - incoming borrow
//           d     - difference bit
//           bout  - outgoing borrow
// Revision: 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : serial_subtractor
// Purpose : Bit-serial unsigned subtractor, LSB first, one bit per clock.
//           Accepts a start in IDLE, spends WIDTH cycles in RUN, then pulses
//           done for one cycle in DONE and returns to IDLE.
// Ports   : clk    - system clock (rising edge)
//           reset  - asynchronous active-high reset
//           start  - request a subtraction (sampled in IDLE only)
//           a, b   - minuend / subtrahend, captured on the accepting edge
//           busy   - high while in RUN
//           done   - one-cycle completion pulse
//           d      - a - b mod 2^WIDTH, held until the next completion
//           bout   - final borrow (a < b unsigned)
//           ovf    - signed overflow, present only when the build macro
//                    SERIAL_SUBTRACTOR_OVF_EN is defined
// Revision: 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SS_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int               CNT_W  = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_brw;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_bout;

  logic             w_diff;
  logic             w_brw_next;

  // --------------------------------------------------------------------------
  // Controller
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_last   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = RUN;
        end
      end
      RUN: begin
        if (r_cnt == C_LAST) begin
          w_last = 1'b1;
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);

  // --------------------------------------------------------------------------
  // Datapath: the operand LSBs feed the single full subtractor each RUN cycle
  // --------------------------------------------------------------------------
  full_subtractor u_fs (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_brw),
    .d    (w_diff),
    .bout (w_brw_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_cnt  <= '0;
      r_d    <= '0;
      r_bout <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_res <= '0;
      r_brw <= 1'b0;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_brw <= w_brw_next;
      // Difference bits enter at the MSB so after WIDTH shifts bit 0 is LSB.
      r_res <= {w_diff, r_res[WIDTH-1:1]};
      // Hold on the last bit so the counter never wraps.
      if (!w_last) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Publish the full result on the DONE-entry edge, including the bit
      // being computed this cycle.
      if (w_last) begin
        r_d    <= {w_diff, r_res[WIDTH-1:1]};
        r_bout <= w_brw_next;
      end
    end
  end

  assign d    = r_d;
  assign bout = r_bout;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  // The operand shift registers lose their MSBs while shifting, so the sign
  // bits are kept separately from the accepting edge.
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      // On the last RUN cycle w_diff is the result MSB.
      r_ovf <= (r_a_msb != r_b_msb) & (w_diff != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module  : tb_serial_subtractor
// Purpose : Directed and random self-checking bench for serial_subtractor
//           (WIDTH = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [3:0] d;
  logic       bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  serial_subtractor #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  // Launches one operation and waits (bounded) for done. Returns in IDLE.
  task automatic run_op(input logic [3:0] ia, input logic [3:0] ib,
                        output logic [3:0] od, output logic ob,
                        output logic oovf, output logic ok);
    ok = 1'b0; od = 'x; ob = 1'bx; oovf = 1'bx;
    @(negedge clk); start = 1'b1; a = ia; b = ib;
    @(posedge clk); #1; start = 1'b0; a = ~ia; b = ~ib;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1; od = d; ob = bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        oovf = ovf;
`else
        oovf = 1'b0;
`endif
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; a = 4'd0; b = 4'd0;
    #2;
    n_checks++;
    if ({busy, done, d, bout} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b d=%h bout=%b, required all 0", busy, done, d, bout);
    end
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    n_checks++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", ovf); end
`endif
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk); start = 1'b1; a = 4'd9; b = 4'd3;
    @(posedge clk); #1; start = 1'b0; a = 4'd0; b = 4'd15;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) begin @(posedge clk); #1; end
      n_checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_run_cycle%0d: busy=%b done=%b, required busy=1 done=0", k, busy, done);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || d !== 4'd6 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b d=%h bout=%b, required 1 0 6 0", done, busy, d, bout);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || d !== 4'd6) begin
      n_fail++;
      $display("FAIL basic_after: done=%b d=%h, required done=0 d=6", done, d);
    end
  endtask

  task automatic test_vectors();
    logic [3:0] va [8] = '{4'd3, 4'd0, 4'd15, 4'd9, 4'd0, 4'd15, 4'd8, 4'd1};
    logic [3:0] vb [8] = '{4'd9, 4'd0, 4'd15, 4'd3, 4'd1, 4'd0,  4'd1, 4'd2};
    logic [3:0] vd [8] = '{4'hA, 4'h0, 4'h0, 4'h6, 4'hF, 4'hF, 4'h7, 4'hF};
    logic       vbo[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [3:0] rd; logic rb, ro, ok;
    for (int i = 0; i < 8; i++) begin
      run_op(va[i], vb[i], rd, rb, ro, ok);
      n_checks++;
      if (!ok || rd !== vd[i] || rb !== vbo[i]) begin
        n_fail++;
        $display("FAIL vector%0d %h-%h: ok=%b d=%h bout=%b, required d=%h bout=%b",
                 i, va[i], vb[i], ok, rd, rb, vd[i], vbo[i]);
      end
    end
  endtask

  // start held high with operands changing every cycle: accepts on edges
  // 0, 6, 12 only, each result from the operands of its accepting edge.
  task automatic test_back_to_back();
    logic [3:0] ta [18];
    logic [3:0] tb [18];
    logic [3:0] ed;
    logic       eb;
    int ph;
    for (int k = 0; k < 18; k++) begin
      ta[k] = 4'((k * 3 + 1) % 16);
      tb[k] = 4'((k * 5 + 7) % 16);
    end
    for (int k = 0; k < 18; k++) begin
      @(negedge clk); start = 1'b1; a = ta[k]; b = tb[k];
      @(posedge clk); #1;
      ph = k % 6;
      n_checks++;
      if (busy !== (ph < 4) || done !== (ph == 4)) begin
        n_fail++;
        $display("FAIL b2b_ctrl edge%0d: busy=%b done=%b, required busy=%b done=%b",
                 k, busy, done, (ph < 4), (ph == 4));
      end
      if (ph == 4) begin
        ed = ta[k-4] - tb[k-4];
        eb = (ta[k-4] < tb[k-4]);
        n_checks++;
        if (d !== ed || bout !== eb) begin
          n_fail++;
          $display("FAIL b2b_result edge%0d: d=%h bout=%b, required d=%h bout=%b", k, d, bout, ed, eb);
        end
      end
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [3:0] rd; logic rb, ro, ok;
    run_op(4'd12, 4'd3, rd, rb, ro, ok);
    @(negedge clk); start = 1'b1; a = 4'd14; b = 4'd5;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, d, bout} !== 7'd0) begin
      n_fail++;
      $display("FAIL abort_async: busy=%b done=%b d=%h bout=%b, required all 0", busy, done, d, bout);
    end
    @(posedge clk); @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold: busy=%b done=%b, required 0 0", busy, done);
    end
    @(negedge clk); reset = 1'b0; start = 1'b1; a = 4'd7; b = 4'd2;
    @(posedge clk); #1; start = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_restart_accept: busy=%b, required 1", busy); end
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL abort_no_done cycle%0d: done=%b, required 0", k, done); end
    end
    @(posedge clk); #1;
    n_checks++;
    if (done !== 1'b1 || d !== 4'd5 || bout !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_restart_result: done=%b d=%h bout=%b, required 1 5 0", done, d, bout);
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  task automatic test_ovf();
    logic [3:0] va [3] = '{4'h8, 4'h7, 4'h5};
    logic [3:0] vb [3] = '{4'h1, 4'hF, 4'h2};
    logic [3:0] vd [3] = '{4'h7, 4'h8, 4'h3};
    logic       vbo[3] = '{1'b0, 1'b1, 1'b0};
    logic       vo [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] rd; logic rb, ro, ok;
    for (int i = 0; i < 3; i++) begin
      run_op(va[i], vb[i], rd, rb, ro, ok);
      n_checks++;
      if (!ok || rd !== vd[i] || rb !== vbo[i] || ro !== vo[i]) begin
        n_fail++;
        $display("FAIL ovf%0d %h-%h: ok=%b d=%h bout=%b ovf=%b, required d=%h bout=%b ovf=%b",
                 i, va[i], vb[i], ok, rd, rb, ro, vd[i], vbo[i], vo[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] ra, rb_in, rd, ed; logic rbo, ro, ok, eo;
    int done0, errs;
    done0 = n_done;
    errs  = 0;
    for (int i = 0; i < 1000; i++) begin
      ra    = 4'($urandom_range(0, 15));
      rb_in = 4'($urandom_range(0, 15));
      run_op(ra, rb_in, rd, rbo, ro, ok);
      ed = ra - rb_in;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      eo = (ra[3] != rb_in[3]) && (ed[3] != ra[3]);
`else
      eo = ro;
`endif
      n_checks++;
      if (!ok || rd !== ed || rbo !== (ra < rb_in) || ro !== eo) begin
        n_fail++;
        errs++;
        if (errs <= 5)
          $display("FAIL random%0d %h-%h: ok=%b d=%h bout=%b ovf=%b, required d=%h bout=%b ovf=%b",
                   i, ra, rb_in, ok, rd, rbo, ro, ed, (ra < rb_in), eo);
      end
    end
    n_checks++;
    if (n_done - done0 != 1000) begin
      n_fail++;
      $display("FAIL random_done_count: got %0d done pulses, required 1000", n_done - done0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_reset_abort();
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    test_ovf();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
